fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
Next-generation instruction fetcher for the SIMD core. It prefetches sequential instructions from program memory into a parametrised instruction buffer and hands them to decode over a valid/ready handshake. It supports PC redirect (branch/jump) with buffer flush and discard of the in-flight response. It sits between program-memory arbitration and the decoder, replacing the single-shot fetch-per-instruction scheme.

Parameters:
PROGRAM_MEM_ADDR_WIDTH, 32, program-memory address width (bits)
DATA_WIDTH, 64, instruction width (bits)
BUF_DEPTH, 4, instruction-buffer entries; power of 2, at least 2
PC_STEP, 1, address increment between sequential instructions

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
enable  in  1  when low, no new memory requests are issued; an outstanding request still completes
redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  in  PROGRAM_MEM_ADDR_WIDTH  new fetch address
prog_mem_read_valid  out  1  read request, held until ack
prog_mem_addr  out  PROGRAM_MEM_ADDR_WIDTH  read address, stable while valid
prog_mem_read_ack  in  1  response strobe; data valid the same cycle
prog_mem_read_data  in  DATA_WIDTH  instruction word
instr_valid  out  1  buffer head holds a valid instruction
instr_ready  in  1  decode accepts the head this cycle
instr  out  DATA_WIDTH  head instruction
instr_pc  out  PROGRAM_MEM_ADDR_WIDTH  address of the head instruction
buf_count  out  $clog2(BUF_DEPTH)+1  number of occupied entries
fetcher_state  out  2  IDLE=0, REQ=1, DRAIN=2

Behaviour:
- Reset: prog_mem_read_valid=0, prog_mem_addr=0, instr_valid=0, instr=0, instr_pc=0, buf_count=0, fetcher_state=IDLE, fetch_pc=0, buffer pointers=0. Reset mid-request drops the request; program memory tolerates the abandoned request.
- Internal fetch_pc is the next address to request. Buffer is a circular FIFO with entries {pc, instr}; pointers wrap modulo BUF_DEPTH.
- Only one request is outstanding at a time.
- IDLE: if enable and buf_count + 0 < BUF_DEPTH (a slot is free), then prog_mem_read_valid<=1, prog_mem_addr<=fetch_pc, go to REQ.
- REQ: on ack, push {prog_mem_addr, data}, set fetch_pc<=fetch_pc+PC_STEP (modulo 2^PROGRAM_MEM_ADDR_WIDTH), and set prog_mem_read_valid<=0.
  - If enable and a slot will still be free after this push (count after push and pop < BUF_DEPTH), issue the next request in the following cycle. Back-to-back requests are allowed, so a request may be re-asserted on the cycle after ack.
  - Otherwise go to IDLE.
- DRAIN: wait for ack, discard the data, then go to IDLE. fetch_pc already holds the redirect target.
- Slot reservation: a request is issued only when count plus outstanding is less than BUF_DEPTH, so a push never overflows.
- Pop: when instr_valid && instr_ready, the head advances. instr and instr_pc are driven combinationally from the head entry. instr_valid = (buf_count != 0).
- Simultaneous push and pop: both take effect and buf_count is unchanged. A push into an empty buffer gives instr_valid=1 on the next cycle.
- Latency: ack at cycle t gives instr_valid=1 at t+1. With an empty buffer in IDLE, the request is issued at t+1 after the enabling condition holds at t.
- Redirect (highest priority):
  - Effects: buffer flushed (count=0, pointers reset), fetch_pc<=redirect_pc, any pop in the same cycle ignored.
  - From IDLE: stay IDLE; the new request is issued the next cycle (address = redirect_pc).
  - From REQ without a same-cycle ack: go to DRAIN, keep prog_mem_read_valid high until ack.
  - From REQ with a same-cycle ack: the data is discarded, then go to IDLE.
  - From DRAIN: stay in DRAIN with the new target.
- enable low: no new issue. A REQ in flight completes and pushes normally; the buffer still drains to decode.
- Address wrap: fetch_pc at max value + PC_STEP wraps to the low bits, with no flag.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_stall_cycles[31:0] (cycles with instr_valid=0 and enable=1), perf_redirects[31:0] (redirect pulses), and perf_discards[15:0] (responses discarded). All reset to 0, saturate at all-ones, and are not cleared by redirect.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, enable=1, memory acks 1 cycle after request, instr_ready=1 → requests to addresses 0,1,2,3…; instr_pc sequence 0,1,2,3 with matching data; no gaps in steady state beyond the memory latency.
- instr_ready=0, BUF_DEPTH=4 → exactly 4 acks accepted, then prog_mem_read_valid stays 0 and buf_count=4. Raising instr_ready for one cycle → one new request issued at fetch_pc=4.
- Redirect to 0x40 while REQ is outstanding at addr 5, ack 3 cycles later → state goes to DRAIN, the data for addr 5 never appears on instr, the next request is at 0x40, and instr_pc=0x40 first.
- Redirect in the same cycle as an ack and a pop → buffer empty next cycle, instr_valid=0, the ack data is dropped, and a request to redirect_pc is issued the next cycle.
- enable deasserted during REQ → the ack is still pushed and no further request is issued. Re-enable → a request resumes at the next sequential PC.
- fetch_pc=0xFFFFFFFF, PC_STEP=1 → the next request address is 0x00000000.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Purpose : sequential instruction prefetcher. It keeps a circular buffer of {pc, instr}
//           entries filled from program memory and drains it to decode over valid/ready.
//           A PC redirect flushes the buffer and discards the response that is in flight.
// Latency : an ack at cycle t gives instr_valid at t+1. From an empty buffer in IDLE, the
//           request goes out one cycle after enable is seen.
// Backpr. : a request is issued only while count + outstanding < BUF_DEPTH, so a push never
//           overflows the buffer. instr_ready low leaves entries in place.
// Ports   : clk/rst (sync, active-high); enable; redirect_valid/redirect_pc;
//           prog_mem_read_valid/addr/ack/data; instr_valid/ready, instr, instr_pc;
//           buf_count; fetcher_state (IDLE=0, REQ=1, DRAIN=2).
// Option  : define FETCH_PERF_CNT_EN to add the saturating counters perf_stall_cycles,
//           perf_redirects and perf_discards.
module fetch_prefetch_unit #(
  parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH             = 64,
  parameter int BUF_DEPTH              = 4,
  parameter int PC_STEP                = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              redirect_valid,
  input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] redirect_pc,
  output logic                              prog_mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] prog_mem_addr,
  input  logic                              prog_mem_read_ack,
  input  logic [DATA_WIDTH-1:0]             prog_mem_read_data,
  output logic                              instr_valid,
  input  logic                              instr_ready,
  output logic [DATA_WIDTH-1:0]             instr,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] instr_pc,
  output logic [$clog2(BUF_DEPTH):0]        buf_count,
  output logic [1:0]                        fetcher_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_stall_cycles,
  output logic [31:0]                       perf_redirects,
  output logic [15:0]                       perf_discards
`endif
);

  localparam int AW = PROGRAM_MEM_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] STEP_C  = AW'(PC_STEP);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e        state_q;
  logic          req_vld_q;
  logic [AW-1:0] req_addr_q;
  logic [AW-1:0] fetch_pc_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] buf_pc_q  [BUF_DEPTH];
  logic [DW-1:0] buf_dat_q [BUF_DEPTH];

  logic          ack;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_d;
  logic [AW-1:0] fetch_pc_inc;

  // The ack only means something while a request is outstanding (REQ or DRAIN).
  assign ack          = prog_mem_read_ack && req_vld_q;
  // A redirect discards the response that arrives in the same cycle, and it also
  // discards any pop in that cycle.
  assign push         = ack && (state_q == ST_REQ) && !redirect_valid;
  assign pop          = (count_q != '0) && instr_ready && !redirect_valid;
  assign count_d      = count_q + CW'(push) - CW'(pop);
  assign fetch_pc_inc = fetch_pc_q + STEP_C;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
      fetch_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]  <= '0;
        buf_dat_q[i] <= '0;
      end
    end else begin
      // Buffer bookkeeping. A redirect flushes the buffer and retargets the fetch.
      if (redirect_valid) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        fetch_pc_q <= redirect_pc;
      end else begin
        if (push) begin
          buf_pc_q[wr_ptr_q]  <= req_addr_q;
          buf_dat_q[wr_ptr_q] <= prog_mem_read_data;
          wr_ptr_q            <= wr_ptr_q + PW'(1);
          fetch_pc_q          <= fetch_pc_inc;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        count_q <= count_d;
      end

      // Request FSM. At most one request is outstanding.
      case (state_q)
        ST_IDLE: begin
          if (!redirect_valid && enable && (count_q < DEPTH_C)) begin
            req_vld_q  <= 1'b1;
            req_addr_q <= fetch_pc_q;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack) begin
            // Back-to-back: keep valid high and move to the next sequential address,
            // but only if the slot after this push/pop is still free.
            if (!redirect_valid && enable && (count_d < DEPTH_C)) begin
              req_addr_q <= fetch_pc_inc;
            end else begin
              req_vld_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end else if (redirect_valid) begin
            // The response to the stale request must still be absorbed.
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The discarded response ends the drain, even if it arrives together with
          // another redirect. Waiting for a second ack here would deadlock.
          if (ack) begin
            req_vld_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          req_vld_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign prog_mem_read_valid = req_vld_q;
  assign prog_mem_addr       = req_addr_q;
  assign instr_valid         = (count_q != '0);
  assign instr               = buf_dat_q[rd_ptr_q];
  assign instr_pc            = buf_pc_q[rd_ptr_q];
  assign buf_count           = count_q;
  assign fetcher_state       = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] redir_q;
  logic [15:0] disc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      redir_q <= '0;
      disc_q  <= '0;
    end else begin
      if (!instr_valid && enable && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (redirect_valid && (redir_q != '1)) begin
        redir_q <= redir_q + 32'd1;
      end
      if (ack && (redirect_valid || (state_q == ST_DRAIN)) && (disc_q != '1)) begin
        disc_q <= disc_q + 16'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_redirects    = redir_q;
  assign perf_discards     = disc_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Purpose : self-checking bench for fetch_prefetch_unit. It uses directed scenarios and
//           then a randomized run, both checked against a queue-based reference model.
// Latency : n/a (testbench)
// Backpr. : drives instr_ready at random and models program memory with a variable latency.
module tb_fetch_prefetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] dat;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        prog_mem_read_valid;
  logic [31:0] prog_mem_addr;
  logic        prog_mem_read_ack;
  logic [63:0] prog_mem_read_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [63:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  buf_count;
  logic [1:0]  fetcher_state;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .PROGRAM_MEM_ADDR_WIDTH(32),
    .DATA_WIDTH            (64),
    .BUF_DEPTH             (4),
    .PC_STEP               (1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .prog_mem_read_valid(prog_mem_read_valid),
    .prog_mem_addr      (prog_mem_addr),
    .prog_mem_read_ack  (prog_mem_read_ack),
    .prog_mem_read_data (prog_mem_read_data),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .instr              (instr),
    .instr_pc           (instr_pc),
    .buf_count          (buf_count),
    .fetcher_state      (fetcher_state)
  );

  int          checks = 0;
  int          failures = 0;
  ent_t        mq[$];          // expected buffer contents, head first
  logic [31:0] req_log[$];     // addresses of the new requests seen
  bit          tainted;        // the outstanding response must be discarded
  logic [31:0] exp_req;        // next address the fetcher must request
  logic [31:0] exp_stream;     // next pc decode must receive
  logic [31:0] held_addr;
  logic        en_at_edge;
  int          wait_cnt;
  int          mem_lat;
  bit          rand_mode;
  bit          new_req;
  logic [31:0] new_req_addr;
  int          pops_total;
  int          acks_total;

  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a * 32'h9E37_79B9 + 32'h0000_1234};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Program memory: it acks a request mem_lat cycles after first seeing it.
  task automatic mem_step();
    new_req = 1'b0;
    if (prog_mem_read_valid) begin
      if (wait_cnt == 0) begin
        new_req      = 1'b1;
        new_req_addr = prog_mem_addr;
        held_addr    = prog_mem_addr;
        req_log.push_back(prog_mem_addr);
        chk("req_addr", prog_mem_addr, exp_req);
        chk("req_slot_free", mq.size() < 4, 1);
        chk("req_enabled", en_at_edge, 1);
        if (rand_mode) mem_lat = $urandom_range(0, 3);
      end else begin
        chk("addr_stable", prog_mem_addr, held_addr);
      end
      if (wait_cnt >= mem_lat) begin
        prog_mem_read_ack  = 1'b1;
        prog_mem_read_data = data_of(prog_mem_addr);
        wait_cnt           = 0;
      end else begin
        prog_mem_read_ack  = 1'b0;
        prog_mem_read_data = {$urandom, $urandom};
        wait_cnt++;
      end
    end else begin
      prog_mem_read_ack  = 1'b0;
      prog_mem_read_data = {$urandom, $urandom};
      wait_cnt           = 0;
    end
  endtask

  // Reference update for the coming posedge, using the inputs and outputs as they are now.
  task automatic model_edge();
    ent_t e;
    ent_t ne;
    if (mq.size() != 0 && instr_ready && !redirect_valid) begin
      e = mq.pop_front();
      chk("stream_pc", e.pc, exp_stream);
      exp_stream = exp_stream + 32'd1;
      pops_total++;
    end
    if (prog_mem_read_ack) begin
      if (!tainted && !redirect_valid) begin
        ne.pc  = prog_mem_addr;
        ne.dat = prog_mem_read_data;
        mq.push_back(ne);
        exp_req = prog_mem_addr + 32'd1;
        acks_total++;
        chk("no_overflow", mq.size() <= 4, 1);
      end
      tainted = 1'b0;
    end
    if (redirect_valid) begin
      if (prog_mem_read_valid && !prog_mem_read_ack) tainted = 1'b1;
      mq.delete();
      exp_req    = redirect_pc;
      exp_stream = redirect_pc;
    end
    en_at_edge = enable;
  endtask

  task automatic model_check();
    chk("buf_count", buf_count, mq.size());
    chk("instr_valid", instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("instr_pc", instr_pc, mq[0].pc);
      chk("instr", instr, mq[0].dat);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    model_check();
    mem_step();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; prog_mem_read_ack = 1'b0; prog_mem_read_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read_valid", prog_mem_read_valid, 0);
    chk("rst_addr", prog_mem_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_buf_count", buf_count, 0);
    chk("rst_state", fetcher_state, 0);
    rst = 1'b0;
    mq.delete(); req_log.delete();
    tainted = 1'b0; exp_req = '0; exp_stream = '0; held_addr = '0;
    en_at_edge = 1'b0; wait_cnt = 0; mem_lat = 1; rand_mode = 1'b0;
    pops_total = 0; acks_total = 0;
    mem_step();
  endtask

  task automatic wait_new_req(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (new_req) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    bit found;
    int p0;

    // Sequential fetch with 1-cycle memory and decode always ready.
    do_reset();
    enable = 1'b1; instr_ready = 1'b1; mem_lat = 1;
    tick();
    chk("first_req_latency", prog_mem_read_valid, 1);
    tick();
    tick();
    chk("ack_to_valid", instr_valid, 1);
    chk("ack_to_valid_pc", instr_pc, 0);
    repeat (9) tick();
    for (int k = 0; k < 4; k++) chk("seq_req_addr", req_log[k], k);
    p0 = pops_total;
    repeat (20) tick();
    chk("steady_throughput", pops_total - p0, 10);

    // Decode stalled: the buffer fills to 4 and requests stop.
    do_reset();
    enable = 1'b1; instr_ready = 1'b0; mem_lat = 1;
    repeat (20) tick();
    chk("full_acks", acks_total, 4);
    chk("full_count", buf_count, 4);
    chk("full_no_req", prog_mem_read_valid, 0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_new_req(6, seen);
    chk("refill_seen", seen, 1);
    chk("refill_addr", new_req_addr, 4);

    // Redirect while the request to addr 5 is outstanding.
    do_reset();
    enable = 1'b1; instr_ready = 1'b1; mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (new_req && new_req_addr == 32'd5) found = 1'b1;
    end
    chk("drain_found_req5", found, 1);
    mem_lat = 3;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("drain_state", fetcher_state, 2);
    wait_new_req(10, seen);
    chk("drain_req_seen", seen, 1);
    chk("drain_req_addr", new_req_addr, 32'h40);
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    chk("drain_instr_seen", found, 1);
    chk("drain_first_pc", instr_pc, 32'h40);

    // Redirect in the same cycle as an ack and a pop.
    do_reset();
    enable = 1'b1; instr_ready = 1'b0; mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (prog_mem_read_ack && instr_valid) begin
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        chk("rdack_instr_valid", instr_valid, 0);
        chk("rdack_count", buf_count, 0);
        found = 1'b1;
      end
    end
    chk("rdack_fired", found, 1);
    wait_new_req(6, seen);
    chk("rdack_req_seen", seen, 1);
    chk("rdack_req_addr", new_req_addr, 32'h80);

    // enable dropped during a request: the ack is still pushed, then fetching pauses.
    do_reset();
    enable = 1'b1; instr_ready = 1'b1; mem_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (new_req && new_req_addr == 32'd2) found = 1'b1;
    end
    chk("en_found_req2", found, 1);
    enable = 1'b0;
    repeat (10) tick();
    chk("en_off_no_req", prog_mem_read_valid, 0);
    chk("en_off_acks", acks_total, 3);
    enable = 1'b1;
    wait_new_req(6, seen);
    chk("en_resume_seen", seen, 1);
    chk("en_resume_addr", new_req_addr, 3);

    // Redirect from IDLE to the top of the address space, then wrap.
    do_reset();
    enable = 1'b1; instr_ready = 1'b1; mem_lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    chk("idle_redirect_state", fetcher_state, 0);
    chk("idle_redirect_no_req", prog_mem_read_valid, 0);
    wait_new_req(6, seen);
    chk("wrap_req1_seen", seen, 1);
    chk("wrap_req1_addr", new_req_addr, 32'hFFFF_FFFF);
    wait_new_req(6, seen);
    chk("wrap_req2_seen", seen, 1);
    chk("wrap_req2_addr", new_req_addr, 32'h0000_0000);

    // Randomized traffic checked by the reference model.
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      end
      tick();
    end
    chk("random_progress", pops_total > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
